// File: rtl/muldiv_unit_if.sv
// Handshake/operand bundle between the EX stage and the iterative
// multiply/divide sequencer. The EX-stage side is the master and the
// sequencer is the slave.
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            kill;
    logic [2:0]      funct3;
    logic [XLEN-1:0] srcA;
    logic [XLEN-1:0] srcB;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic            stall;

    modport master (
        output start, kill, funct3, srcA, srcB,
        input  busy, done, result, stall
    );

    modport slave (
        input  start, kill, funct3, srcA, srcB,
        output busy, done, result, stall
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide sequencer. One radix-2 step per cycle
// for exactly XLEN cycles on every op, including divide-by-zero and
// signed overflow, so the pipeline sees a fixed latency. Signed ops run
// on operand magnitudes and the sign is restored after the loop.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state;
    logic [CW-1:0]     count;
    logic [2:0]        op;
    logic [XLEN-1:0]   opnd;        // multiplicand for MUL*, divisor for DIV*
    logic [2*XLEN-1:0] acc;         // product, or {remainder, quotient}
    logic [2*XLEN-1:0] acc_next;
    logic              neg_res;     // product / quotient must be negated
    logic              rem_neg;     // remainder takes the dividend sign
    logic              div_zero;
    logic              div_ovf;
    logic              busy_r;
    logic              done_r;
    logic [XLEN-1:0]   result_r;
    logic [XLEN-1:0]   result_next;

    // Operand conditioning for the op being offered in IDLE
    logic            a_signed_in, b_signed_in;
    logic            a_neg_in, b_neg_in;
    logic [XLEN-1:0] a_mag_in, b_mag_in;
    logic            div_zero_in, div_ovf_in;
    logic            accept;

    // Magnitude in XLEN unsigned bits; abs(most-negative) wraps to itself,
    // which is the correct unsigned magnitude.
    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v,
                                                  input logic neg);
        return neg ? -v : v;
    endfunction

    // Sign restoration, special-case override and result selection.
    function automatic logic [XLEN-1:0] select_result(
        input logic [2:0]        f,
        input logic [2*XLEN-1:0] a,
        input logic              ng,
        input logic              rn,
        input logic              dz,
        input logic              ov
    );
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   quo;
        logic [XLEN-1:0]   rem;
        prod = ng ? -a : a;
        quo  = ng ? -a[XLEN-1:0] : a[XLEN-1:0];
        rem  = rn ? -a[2*XLEN-1:XLEN] : a[2*XLEN-1:XLEN];
        if (dz) begin
            quo = '1;
        end
        if (ov) begin
            quo = {1'b1, {(XLEN-1){1'b0}}};
            rem = '0;
        end
        if (!f[2]) begin
            return (f[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end
        return f[1] ? rem : quo;
    endfunction

    assign a_signed_in = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                         (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
    assign b_signed_in = (bus.funct3 == 3'b001) ||
                         (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
    assign a_neg_in    = a_signed_in & bus.srcA[XLEN-1];
    assign b_neg_in    = b_signed_in & bus.srcB[XLEN-1];
    assign a_mag_in    = magnitude(bus.srcA, a_neg_in);
    assign b_mag_in    = magnitude(bus.srcB, b_neg_in);
    assign div_zero_in = bus.funct3[2] && (bus.srcB == '0);
    assign div_ovf_in  = bus.funct3[2] && !bus.funct3[0] &&
                         (bus.srcA == {1'b1, {(XLEN-1){1'b0}}}) &&
                         (bus.srcB == '1);
    assign accept      = (state == IDLE) && bus.start && !bus.kill;

    // One radix-2 step: shift-add for multiply, restoring shift-subtract for divide
    always_comb begin
        logic [XLEN:0] sum;
        logic [XLEN:0] shifted;
        logic [XLEN:0] diff;
        logic          ge;
        sum      = '0;
        shifted  = '0;
        diff     = '0;
        ge       = 1'b0;
        acc_next = acc;
        if (!op[2]) begin
            sum      = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? opnd : {XLEN{1'b0}})};
            acc_next = {sum, acc[XLEN-1:1]};
        end else begin
            shifted  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
            ge       = (shifted >= {1'b0, opnd});
            diff     = shifted - {1'b0, opnd};
            acc_next = {(ge ? diff[XLEN-1:0] : shifted[XLEN-1:0]), acc[XLEN-2:0], ge};
        end
        result_next = select_result(op, acc_next, neg_res, rem_neg, div_zero, div_ovf);
    end

    // Sequencer FSM with registered busy/done/result
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            count    <= '0;
            op       <= '0;
            opnd     <= '0;
            acc      <= '0;
            neg_res  <= 1'b0;
            rem_neg  <= 1'b0;
            div_zero <= 1'b0;
            div_ovf  <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (accept) begin
                        op       <= bus.funct3;
                        opnd     <= bus.funct3[2] ? b_mag_in : a_mag_in;
                        acc      <= {{XLEN{1'b0}}, (bus.funct3[2] ? a_mag_in : b_mag_in)};
                        neg_res  <= a_neg_in ^ b_neg_in;
                        rem_neg  <= a_neg_in;
                        div_zero <= div_zero_in;
                        div_ovf  <= div_ovf_in;
                        count    <= '0;
                        busy_r   <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    if (bus.kill) begin
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        acc   <= acc_next;
                        count <= count + 1'b1;
                        if (count == CW'(XLEN-1)) begin
                            result_r <= result_next;
                            done_r   <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // A flush arriving in the DONE cycle must hide the pulse in that same
    // cycle, so the registered done is qualified by the live kill.
    assign bus.done   = done_r & ~bus.kill;
    assign bus.busy   = busy_r;
    assign bus.result = result_r;
    assign bus.stall  = accept || (state == CALC);
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases, boundary
// scenarios (kill, reset, start while busy) and randomized ops against a
// plain-arithmetic reference model.
module tb_muldiv_unit;
    logic clk;
    logic reset_n;
    int   n_tests;
    int   n_fail;
    logic [31:0] last_result;

    muldiv_unit_if #(.XLEN(32)) bus ();

    muldiv_unit #(.XLEN(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // RV32M semantics from 64-bit arithmetic and the divide special cases
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] p;
        int sa;
        int sb;
        logic ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
            3'd2: begin p = {{32{a[31]}}, a} * {32'b0, b}; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return sa / sb;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return sa % sb;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] rnd_opnd();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return {24'h0, r[7:0]};
            default: return r;
        endcase
    endfunction

    // Starts an op in the current cycle (called just after a falling edge).
    // kill_at: cycle offset after acceptance at which kill is raised
    // (1..32 = CALC, 33 = DONE), or -1 for none. noise drives random
    // start/operands while busy, which must be ignored.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input bit noise, input int kill_at);
        logic [31:0] exp;
        logic [31:0] r;
        logic        bad;
        exp        = ref_model(f3, a, b);
        bus.start  = 1'b1;
        bus.kill   = 1'b0;
        bus.funct3 = f3;
        bus.srcA   = a;
        bus.srcB   = b;
        #1;
        check_val("stall_accept", {31'b0, bus.stall}, 32'h1);
        bad = 1'b0;
        for (int c = 1; c <= 32; c++) begin
            @(negedge clk);
            if (noise) begin
                r          = $urandom;
                bus.start  = r[0];
                bus.funct3 = r[3:1];
                bus.srcA   = $urandom;
                bus.srcB   = $urandom;
            end else begin
                bus.start = 1'b0;
            end
            if (kill_at == c) begin
                bus.start = 1'b0;
                bus.kill  = 1'b1;
                @(negedge clk);
                bus.kill = 1'b0;
                #1;
                check_val("kill_busy", {31'b0, bus.busy}, 32'h0);
                check_val("kill_done", {31'b0, bus.done}, 32'h0);
                check_val("kill_stall", {31'b0, bus.stall}, 32'h0);
                check_val("kill_result", bus.result, last_result);
                return;
            end
            #1;
            if (bus.stall !== 1'b1 || bus.busy !== 1'b1 || bus.done !== 1'b0) bad = 1'b1;
        end
        check_val("calc_window", {31'b0, bad}, 32'h0);
        @(negedge clk);
        if (noise) begin
            bus.start = 1'b1;
            bus.srcA  = $urandom;
        end else begin
            bus.start = 1'b0;
        end
        if (kill_at == 33) bus.kill = 1'b1;
        #1;
        if (kill_at == 33) begin
            check_val("done_kill_pulse", {31'b0, bus.done}, 32'h0);
        end else begin
            check_val("done_pulse", {31'b0, bus.done}, 32'h1);
            check_val("done_stall", {31'b0, bus.stall}, 32'h0);
            check_val($sformatf("result_f%0d_%08h_%08h", f3, a, b), bus.result, exp);
        end
        // The result register is loaded on the edge entering DONE.
        last_result = exp;
        @(negedge clk);
        bus.start = 1'b0;
        bus.kill  = 1'b0;
        #1;
        check_val("idle_busy", {31'b0, bus.busy}, 32'h0);
        check_val("idle_done", {31'b0, bus.done}, 32'h0);
    endtask

    logic [2:0]  dir_f3 [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                                 3'd5, 3'd7, 3'd4, 3'd6};
    logic [31:0] dir_a  [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                                 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] dir_b  [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                 32'd2, 32'd2, 32'd7, 32'd7,
                                 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] dir_e  [12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                                 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                                 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};

    initial begin
        logic [31:0] r;
        n_tests     = 0;
        n_fail      = 0;
        last_result = 32'h0;
        reset_n     = 1'b0;
        bus.start   = 1'b0;
        bus.kill    = 1'b0;
        bus.funct3  = 3'd0;
        bus.srcA    = 32'h0;
        bus.srcB    = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        check_val("rst_busy", {31'b0, bus.busy}, 32'h0);
        check_val("rst_done", {31'b0, bus.done}, 32'h0);
        check_val("rst_result", bus.result, 32'h0);
        check_val("rst_stall", {31'b0, bus.stall}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Anchor the reference model to the hand-worked vectors
        for (int i = 0; i < 12; i++) begin
            check_val("model_vec", ref_model(dir_f3[i], dir_a[i], dir_b[i]), dir_e[i]);
        end
        for (int i = 0; i < 12; i++) begin
            run_op(dir_f3[i], dir_a[i], dir_b[i], 1'b0, -1);
        end

        // start while busy and in DONE must not disturb the running op
        run_op(3'd1, 32'h1234_5678, 32'hFEDC_BA98, 1'b1, -1);
        run_op(3'd6, 32'h8765_4321, 32'h0000_0013, 1'b1, -1);

        // kill in DONE hides the pulse; then a normal op
        run_op(3'd4, 32'd100, 32'd7, 1'b0, 33);
        run_op(3'd0, 32'd3, 32'd5, 1'b0, -1);

        // kill at CALC count 10, then an immediate new op
        run_op(3'd3, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 11);
        run_op(3'd5, 32'hDEAD_BEEF, 32'd1000, 1'b0, -1);

        // start together with kill in IDLE is refused
        bus.start  = 1'b1;
        bus.kill   = 1'b1;
        bus.funct3 = 3'd0;
        #1;
        check_val("startkill_stall", {31'b0, bus.stall}, 32'h0);
        @(negedge clk);
        bus.start = 1'b0;
        bus.kill  = 1'b0;
        #1;
        check_val("startkill_busy", {31'b0, bus.busy}, 32'h0);

        // reset in the middle of CALC
        bus.start  = 1'b1;
        bus.funct3 = 3'd0;
        bus.srcA   = 32'd9;
        bus.srcB   = 32'd9;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        #1;
        check_val("midrst_busy", {31'b0, bus.busy}, 32'h0);
        check_val("midrst_done", {31'b0, bus.done}, 32'h0);
        check_val("midrst_result", bus.result, 32'h0);
        check_val("midrst_stall", {31'b0, bus.stall}, 32'h0);
        reset_n     = 1'b1;
        last_result = 32'h0;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (bus.done !== 1'b0) check_val("midrst_no_done", {31'b0, bus.done}, 32'h0);
        end
        check_val("midrst_idle", {31'b0, bus.busy}, 32'h0);

        // randomized ops, occasionally with noise on start
        for (int i = 0; i < 200; i++) begin
            r = $urandom;
            run_op(r[2:0], rnd_opnd(), rnd_opnd(), (r[7:4] == 4'h0), -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "timeout");
    end
endmodule
